// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Purpose:
//   Fetch-stage program counter for the RISC-V pipeline. A single 32-bit
//   register holds the current fetch address. On every rising clock edge it
//   does one of four things: loads the reset vector, holds (stall), loads a
//   redirect target from the ALU, or advances by PC_INC. pc_out is taken
//   straight from the register, so there is no combinational path from any
//   input to the output.
//
// Parameters:
//   RESET_PC  fetch address loaded while reset is asserted (default 32'h2000)
//   PC_INC    sequential increment per cycle (default 4)
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous reset, active low (0 = in reset)
//   alu_out        in  32   redirect target for branches/jumps
//   pc_sel         in   1   0 = sequential, 1 = take alu_out
//   stall          in   1   1 = hold current PC
//   pc_out         out 32   current PC (register output)
//   pc_misaligned  out  1   only when PC_ALIGN_CHECK_EN is defined: set for
//                           one update after a redirect whose target had
//                           non-zero low two bits
//
// Build option:
//   PC_ALIGN_CHECK_EN - when defined, redirect targets are forced to a word
//   boundary and the pc_misaligned flag is added. When undefined, alu_out is
//   loaded unmodified and the flag port does not exist.
// -----------------------------------------------------------------------------
module program_counter #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_out,
    input  logic        pc_sel,
    input  logic        stall,
    output logic [31:0] pc_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        pc_misaligned
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] redirect_target;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned_q;
    logic misaligned_d;

    // Instruction fetch is word-based; drop the byte offset of the target.
    assign redirect_target = {alu_out[31:2], 2'b00};
`else
    assign redirect_target = alu_out;
`endif

    // Next-state selection. The nested if/else ordering matters: while
    // reset or stall is active, pc_sel and alu_out are never evaluated, so
    // unknown values on them cannot leak into the register.
    always_comb begin
        pc_d = pc_q;
`ifdef PC_ALIGN_CHECK_EN
        misaligned_d = 1'b0;
`endif
        if (!reset) begin
            pc_d = RESET_PC;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pc_sel) begin
            pc_d = redirect_target;
`ifdef PC_ALIGN_CHECK_EN
            misaligned_d = (alu_out[1:0] != 2'b00);
`endif
        end else begin
            // 32-bit add wraps naturally modulo 2^32.
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
`ifdef PC_ALIGN_CHECK_EN
        misaligned_q <= misaligned_d;
`endif
    end

    assign pc_out = pc_q;
`ifdef PC_ALIGN_CHECK_EN
    assign pc_misaligned = misaligned_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Directed test of program_counter: reset with hostile inputs, sequential
// fetch, redirects, stall priority, wrap-around, back-to-back redirects and
// reset asserted in the middle of a redirect/stall. Expected values are
// written out by hand for the default parameters (RESET_PC = 32'h2000,
// PC_INC = 4). Build with PC_ALIGN_CHECK_EN defined to exercise the
// alignment variant; the expected values adjust accordingly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] alu_out;
    logic        pc_sel;
    logic        stall;
    logic [31:0] pc_out;
`ifdef PC_ALIGN_CHECK_EN
    logic        pc_misaligned;
`endif

    int checks;
    int failures;

    program_counter dut (
        .clk          (clk),
        .reset        (reset),
        .alu_out      (alu_out),
        .pc_sel       (pc_sel),
        .stall        (stall),
        .pc_out       (pc_out)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .pc_misaligned(pc_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs on the falling edge, let one rising edge happen, then
    // sample 1 ns after it and compare against the hand-computed value.
    task automatic step(input logic        rst_v,
                        input logic        stall_v,
                        input logic        sel_v,
                        input logic [31:0] alu_v,
                        input logic [31:0] exp_pc,
                        input string       tag);
        @(negedge clk);
        reset   = rst_v;
        stall   = stall_v;
        pc_sel  = sel_v;
        alu_out = alu_v;
        @(posedge clk);
        #1;
        checks++;
        assert (pc_out === exp_pc) else begin
            failures++;
            $error("FAIL %s: pc_out=%h expected=%h", tag, pc_out, exp_pc);
        end
        $display("step %-14s rst=%b stall=%b sel=%b alu=%h -> pc_out=%h (exp %h)",
                 tag, rst_v, stall_v, sel_v, alu_v, pc_out, exp_pc);
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic check_mis(input logic exp_m, input string tag);
        checks++;
        assert (pc_misaligned === exp_m) else begin
            failures++;
            $error("FAIL %s: pc_misaligned=%b expected=%b", tag, pc_misaligned, exp_m);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        stall    = 1'b1;
        pc_sel   = 1'b1;
        alu_out  = 32'hDEAD_BEEF;

        // Reset dominates stall/redirect inputs.
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_2000, "reset_1");
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_2000, "reset_2");
`ifdef PC_ALIGN_CHECK_EN
        check_mis(1'b0, "mis_reset");
`endif

        // Sequential fetch after reset release.
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2004, "seq_1");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2008, "seq_2");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_200C, "seq_3");

        // Single redirect then sequential.
        step(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, "redir");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_3004, "redir_seq");

        // Stall beats redirect; release applies redirect sampled that edge.
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_3004, "stall_1");
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_3004, "stall_2");
        step(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0000_3004, "stall_3");
        step(1'b1, 1'b0, 1'b1, 32'h0000_4000, 32'h0000_4000, "stall_rel");

        // Wrap-around at the top of the address space.
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "wrap_redir");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0000, "wrap_0");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0004, "wrap_4");

        // Reset asserted while a redirect is requested.
        step(1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_2000, "mid_reset");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2004, "post_reset");

        // Back-to-back redirects, then stall and sequential release.
        step(1'b1, 1'b0, 1'b1, 32'h0000_A000, 32'h0000_A000, "b2b_1");
        step(1'b1, 1'b0, 1'b1, 32'h0000_B004, 32'h0000_B004, "b2b_2");
        step(1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_B004, "hold");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_B008, "hold_rel");

        // Unaligned redirect target.
`ifdef PC_ALIGN_CHECK_EN
        step(1'b1, 1'b0, 1'b1, 32'h0000_5002, 32'h0000_5000, "unaligned");
        check_mis(1'b1, "mis_set");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_5004, "unaligned_seq");
        check_mis(1'b0, "mis_clear");
        step(1'b1, 1'b0, 1'b1, 32'h0000_6003, 32'h0000_6000, "unaligned_2");
        check_mis(1'b1, "mis_set_2");
        step(1'b1, 1'b1, 1'b1, 32'h0000_7001, 32'h0000_6000, "mis_hold");
        check_mis(1'b0, "mis_hold_clr");
`else
        step(1'b1, 1'b0, 1'b1, 32'h0000_5002, 32'h0000_5002, "unaligned");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_5006, "unaligned_seq");
`endif

        // Reset asserted during a stall; nothing pending survives.
        step(1'b0, 1'b1, 1'b1, 32'h0000_9000, 32'h0000_2000, "stall_reset");
        step(1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_2004, "final_seq");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
